// File: rtl/mask_pop_unit.sv
// mask_pop_unit: streams mask beats and reports either the population count
// or the index of the first set bit among the first vl elements.
module mask_pop_unit #(
  parameter int DATA_WIDTH = 32,
  parameter int MAX_BEATS  = 8,
  parameter int RES_W      = $clog2(DATA_WIDTH*MAX_BEATS)+1
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  start_i,
  input  logic                  mode_i,
  input  logic [RES_W-1:0]      vl_i,
  input  logic                  valid_i,
  input  logic [DATA_WIDTH-1:0] data_i,
  output logic                  ready_o,
  output logic                  busy_o,
  output logic                  done_o,
  output logic [RES_W-1:0]      result_o
);
  typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;
  localparam int SH = $clog2(DATA_WIDTH);
  localparam logic [RES_W-1:0] MAX_EL = RES_W'(DATA_WIDTH*MAX_BEATS);
  localparam logic [RES_W-1:0] DW_R = RES_W'(DATA_WIDTH);
  state_t state_q, state_d;
  logic mode_q, mode_d, found_q, found_d, last, hit, found_n;
  logic [RES_W-1:0] vl_q, vl_d, beat_q, beat_d, acc_q, acc_d, res_q, res_d;
  logic [RES_W-1:0] vl_c, base, rem, pop, idx, acc_n, res_n;
  logic [DATA_WIDTH-1:0] masked;
  // per-beat datapath: mask off elements past vl, then count and locate
  always_comb begin
    vl_c = vl_i > MAX_EL ? MAX_EL : vl_i;
    base = beat_q << SH;
    rem = vl_q - base;
    last = rem <= DW_R;
    pop = '0;
    idx = '0;
    for (int k = DATA_WIDTH-1; k >= 0; k--) begin
      masked[k] = data_i[k] && (RES_W'(k) < rem);
      pop = pop + RES_W'(masked[k]);
      if (masked[k]) idx = RES_W'(k);
    end
    hit = |masked;
    found_n = found_q | hit;
    acc_n = mode_q ? ((found_q || !hit) ? acc_q : base + idx) : acc_q + pop;
    res_n = (mode_q && !found_n) ? '1 : acc_n;
  end
  always_comb begin
    state_d = state_q;
    mode_d = mode_q;
    vl_d = vl_q;
    beat_d = beat_q;
    acc_d = acc_q;
    found_d = found_q;
    res_d = res_q;
    if (state_q == IDLE && start_i) begin
      mode_d = mode_i;
      vl_d = vl_c;
      acc_d = '0;
      beat_d = '0;
      found_d = 1'b0;
      state_d = vl_c == '0 ? DONE : ACCUM;
      if (vl_c == '0) res_d = mode_i ? '1 : '0;
    end else if (state_q == ACCUM && valid_i) begin
      acc_d = acc_n;
      found_d = found_n;
      beat_d = beat_q + 1'b1;
      state_d = last ? DONE : ACCUM;
      if (last) res_d = res_n;
    end else if (state_q == DONE) begin
      state_d = IDLE;
    end
  end
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      mode_q <= 1'b0;
      vl_q <= '0;
      beat_q <= '0;
      acc_q <= '0;
      found_q <= 1'b0;
      res_q <= '0;
    end else begin
      state_q <= state_d;
      mode_q <= mode_d;
      vl_q <= vl_d;
      beat_q <= beat_d;
      acc_q <= acc_d;
      found_q <= found_d;
      res_q <= res_d;
    end
  end
  assign ready_o = state_q == ACCUM;
  assign busy_o = state_q != IDLE;
  assign done_o = state_q == DONE;
  assign result_o = res_q;
endmodule

// File: tb/tb_mask_pop_unit.sv
// tb_mask_pop_unit: vector table, hand sequences and randomized ops vs. an element-level model.
module tb_mask_pop_unit;
  logic clk = 1'b0, rst_i = 1'b1, start_i = 1'b0, mode_i = 1'b0, valid_i = 1'b0;
  logic [8:0] vl_i = '0;
  logic [31:0] data_i = '0;
  logic ready_o, busy_o, done_o;
  logic [8:0] result_o;
  logic [31:0] bt [8];
  int n_tests = 0, n_fail = 0;

  mask_pop_unit dut (.clk_i(clk), .rst_i(rst_i), .start_i(start_i), .mode_i(mode_i), .vl_i(vl_i),
    .valid_i(valid_i), .data_i(data_i), .ready_o(ready_o), .busy_o(busy_o), .done_o(done_o),
    .result_o(result_o));

  always #5 clk = ~clk;

  typedef struct {
    logic m; logic [8:0] vl; logic [31:0] b0, b1, b2, rest; bit gaps, junk; logic [8:0] exp;
  } vec_t;
  vec_t tv [12];

  task automatic chk(input string n, input logic [8:0] got, input logic [8:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", n, got, exp, $time);
    end
  endtask

  function automatic logic [8:0] model(input logic m, input int vl);
    int v = vl > 256 ? 256 : vl;
    int cnt = 0, first = -1;
    for (int e = 0; e < v; e++)
      if (bt[e/32][e%32]) begin
        cnt++;
        if (first < 0) first = e;
      end
    return m ? (first < 0 ? 9'h1ff : 9'(first)) : 9'(cnt);
  endfunction

  task automatic do_op(input logic m, input logic [8:0] vl, input logic [8:0] exp, input bit gaps, input bit junk);
    int nb = ((vl > 256 ? 256 : int'(vl)) + 31) / 32;
    if (junk) begin
      valid_i = 1'b1; data_i = '1;
      @(negedge clk);
      chk("idle_valid_busy", busy_o, 0);
      valid_i = 1'b0;
    end
    start_i = 1'b1; mode_i = m; vl_i = vl;
    @(negedge clk);
    start_i = 1'b0;
    chk("busy", busy_o, 1);
    if (nb == 0) begin
      chk("zero_done", done_o, 1);
      chk("zero_ready", ready_o, 0);
      chk("zero_result", result_o, exp);
    end
    for (int b = 0; b < nb; b++) begin
      if (gaps) repeat ($urandom_range(0, 2)) begin
        chk("gap_ready", ready_o, 1);
        chk("gap_done", done_o, 0);
        @(negedge clk);
      end
      chk("ready", ready_o, 1);
      chk("early_done", done_o, 0);
      valid_i = 1'b1; data_i = bt[b];
      if (junk) begin start_i = 1'b1; mode_i = ~m; vl_i = 9'd8; end
      @(negedge clk);
      valid_i = 1'b0; start_i = 1'b0;
    end
    if (nb > 0) begin
      chk("done", done_o, 1);
      chk("result", result_o, exp);
    end
    @(negedge clk);
    chk("done_clear", done_o, 0);
    chk("idle", busy_o, 0);
    chk("hold", result_o, exp);
  endtask

  initial begin
    tv[0]  = '{0, 64,  32'hFFFF_FFFF, 32'h1, 0, 0, 0, 1, 33};
    tv[1]  = '{0, 40,  32'h0, 32'hFFFF_FFFF, 0, 0, 0, 0, 8};
    tv[2]  = '{1, 96,  32'h0, 32'h100, 32'h1, 0, 1, 1, 40};
    tv[3]  = '{1, 16,  32'hFFFF_0000, 0, 0, 0, 0, 0, 9'h1ff};
    tv[4]  = '{0, 0,   '1, '1, '1, '1, 0, 0, 0};
    tv[5]  = '{1, 0,   '1, '1, '1, '1, 0, 1, 9'h1ff};
    tv[6]  = '{0, 300, '1, '1, '1, '1, 1, 0, 256};
    tv[7]  = '{1, 256, 0, 0, 0, 32'h8000_0000, 1, 0, 127};
    tv[8]  = '{1, 33,  0, 32'h2, 0, 0, 0, 0, 9'h1ff};
    tv[9]  = '{1, 33,  0, 32'h1, 0, 0, 0, 0, 32};
    tv[10] = '{0, 255, '1, '1, '1, '1, 0, 0, 255};
    tv[11] = '{0, 32,  32'hF0F0_F0F0, 0, 0, 0, 0, 0, 16};
    repeat (2) @(negedge clk);
    chk("rst_busy", busy_o, 0);
    chk("rst_ready", ready_o, 0);
    chk("rst_done", done_o, 0);
    chk("rst_result", result_o, 0);
    rst_i = 1'b0;
    for (int i = 0; i < 12; i++) begin
      bt[0] = tv[i].b0; bt[1] = tv[i].b1; bt[2] = tv[i].b2;
      for (int j = 3; j < 8; j++) bt[j] = tv[i].rest;
      do_op(tv[i].m, tv[i].vl, tv[i].exp, tv[i].gaps, tv[i].junk);
    end
    // reset in the middle of an operation, then restart right after release
    bt[0] = 32'h1; bt[1] = 32'h3; bt[2] = 32'h7;
    start_i = 1'b1; mode_i = 1'b0; vl_i = 9'd96;
    @(negedge clk);
    start_i = 1'b0; valid_i = 1'b1; data_i = bt[0];
    @(negedge clk);
    valid_i = 1'b0;
    #2 rst_i = 1'b1;
    #1;
    chk("midrst_busy", busy_o, 0);
    chk("midrst_ready", ready_o, 0);
    chk("midrst_done", done_o, 0);
    chk("midrst_result", result_o, 0);
    @(negedge clk);
    rst_i = 1'b0;
    bt[0] = 32'hF0;
    do_op(0, 9'd32, 9'd4, 0, 0);
    for (int i = 0; i < 40; i++) begin
      logic m = 1'($urandom);
      logic [8:0] vl = 9'($urandom_range(0, 300));
      for (int j = 0; j < 8; j++)
        bt[j] = ($urandom % 3 == 0) ? 32'h0 : ($urandom & $urandom & $urandom);
      do_op(m, vl, model(m, int'(vl)), 1, 1'($urandom));
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/mask_pop_unit.md
MASK_POP_UNIT -- requirements
Module: mask_pop_unit

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, mask bits per input beat (power of two, >=8).
REQ-002 SHALL have parameter MAX_BEATS, default 8, max beats per operation (power of two, >=1).
REQ-003 SHALL have parameter RES_W, default $clog2(DATA_WIDTH*MAX_BEATS)+1, width of vl and result.
REQ-004 SHALL have port clk_i  input  1  single clock, all state on rising edge.
REQ-005 SHALL have port rst_i  input  1  reset, asynchronous, active-high.
REQ-006 SHALL have port start_i  input  1  begin operation, sampled only in IDLE.
REQ-007 SHALL have port mode_i  input  1  0 = count set bits (cpop), 1 = index of first set bit (first); latched on start.
REQ-008 SHALL have port vl_i  input  RES_W  active element count, 0..DATA_WIDTH*MAX_BEATS; latched on start.
REQ-009 SHALL have port valid_i  input  1  data_i beat valid.
REQ-010 SHALL have port data_i  input  DATA_WIDTH  mask beat; bit k of beat b is element b*DATA_WIDTH+k.
REQ-011 SHALL have port ready_o  output  1  beat accepted when valid_i && ready_o.
REQ-012 SHALL have port busy_o  output  1  high in any state other than IDLE.
REQ-013 SHALL have port done_o  output  1  one-cycle pulse, result_o valid.
REQ-014 SHALL have port result_o  output  RES_W  cpop count or first index; held until next start.

Function
REQ-015 SHALL implement states IDLE, ACCUM, DONE.
REQ-016 IDLE: start_i=1 with vl_i>0 SHALL latch mode/vl, clear accumulator, clear beat counter, go to ACCUM.
REQ-017 IDLE: start_i=1 with vl_i=0 SHALL go to DONE; result = 0 (cpop) or all-ones (first).
REQ-018 ready_o SHALL equal 1 only in ACCUM (no combinational path from valid_i).
REQ-019 Beats required SHALL be ceil(vl/DATA_WIDTH); beat counter increments per accepted beat.
REQ-020 Elements with index >= vl SHALL be masked to 0 before counting (partial final beat).
REQ-021 cpop: accumulator += popcount(masked beat), width RES_W, never overflows for legal vl.
REQ-022 first: on first accepted beat with nonzero masked data, record b*DATA_WIDTH + lowest set bit index; later beats SHALL NOT change it.
REQ-023 first with no set bit in any active element SHALL yield result all-ones (-1 in RES_W).
REQ-024 Acceptance of final beat SHALL move to DONE; result_o registered in that same edge.
REQ-025 DONE SHALL last exactly one cycle, assert done_o, then return to IDLE.
REQ-026 Latency: done_o SHALL assert the cycle after the final beat handshake.
REQ-027 start_i while busy_o=1 SHALL be ignored; valid_i outside ACCUM SHALL be ignored.
REQ-028 valid_i low in ACCUM SHALL stall without state change (arbitrary gaps allowed).
REQ-029 vl_i > DATA_WIDTH*MAX_BEATS SHALL be clamped to DATA_WIDTH*MAX_BEATS.
REQ-030 result_o SHALL hold last value through IDLE until next DONE update.

Reset
REQ-031 rst_i SHALL asynchronously force IDLE, result_o=0, done_o=0, ready_o=0, busy_o=0, counters/accumulator 0.
REQ-032 rst_i mid-ACCUM SHALL abandon the operation; no done_o pulse for it after release.
REQ-033 First start_i SHALL be honoured on the first rising edge after rst_i deasserts.

Verification
REQ-034 DW=32: start cpop vl=64, beats 0xFFFF_FFFF, 0x0000_0001 -> done_o 1 cycle after 2nd beat, result_o=33.
REQ-035 DW=32: start cpop vl=40, beats 0x0000_0000, 0xFFFF_FFFF -> upper 24 bits masked, result_o=8.
REQ-036 DW=32: start first vl=96, beats 0, 0x0000_0100, 0x1 with valid_i gaps -> result_o=40, no earlier done_o.
REQ-037 start first vl=16, beat 0xFFFF_0000 -> result_o all-ones; start cpop vl=0 -> done_o 1 cycle later, result_o=0, no ready_o.
REQ-038 rst_i asserted after 1 of 3 beats -> outputs zero immediately; new start vl=32, beat 0xF0 -> result_o=4, single done_o.
REQ-039 start_i pulsed during ACCUM with different vl/mode -> ignored; original operation result unchanged.
